// File: rtl/gpio_arb_pkg.sv
// Shared types and constants for the GPIO header arbiter.
package gpio_arb_pkg;

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

  typedef logic req_idx_t;

  localparam int NUM_REQ    = 2;
  localparam int TURN_CNT_W = 4;

  function automatic logic [NUM_REQ-1:0] grant_vec(input req_idx_t k);
    return k ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchronizer for the GPIO read-back path; chain clears on reset.
module gpio_sync #(
  parameter int W           = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] pins,
  output logic [W-1:0] synced
);

  logic [W-1:0] chain [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= pins;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign synced = chain[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_port_arbiter.sv
// Round-robin owner of the GPIO header with all-Z turnaround between owners.
// Optional edge detection on the read-back is enabled by GPIO_EDGE_DET_EN.
module gpio_port_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int W           = 32,
  parameter int TURN_CYC    = 2,
  parameter int MAX_HOLD    = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic         CLOCK_50,
  input  logic         Resetn,
  inout  wire  [W-1:0] GPIO,
  input  logic [1:0]   req,
  output logic [1:0]   gnt,
  input  logic [W-1:0] wr_data0,
  input  logic [W-1:0] wr_oe0,
  input  logic [W-1:0] wr_data1,
  input  logic [W-1:0] wr_oe1,
  output logic [W-1:0] rd_data,
  output logic         busy,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

  state_t                  state_q, state_d;
  logic [1:0]              gnt_d;
  req_idx_t                last_q, last_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic [TURN_CNT_W-1:0]   turn_q, turn_d;
  logic [W-1:0]            out_q, out_d;
  logic [W-1:0]            oe_q, oe_d;
  logic                    waiting;
  logic                    preempt;

  function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
    return (&v) ? v : v + HOLD_W'(1);
  endfunction

  assign waiting = req[~last_q];
  assign preempt = (MAX_HOLD != 0) && waiting && (hold_q == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      gnt     <= '0;
      last_q  <= 1'b1;
      hold_q  <= '0;
      turn_q  <= '0;
      out_q   <= '0;
      oe_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
    end
  end

  // last_q doubles as the current owner index while in OWN
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    last_d  = last_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    out_d   = out_q;
    oe_d    = oe_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = OWN;
          last_d  = (req == 2'b11) ? ~last_q : req[1];
          gnt_d   = grant_vec(last_d);
          hold_d  = '0;
        end
      end
      OWN: begin
        out_d = last_q ? wr_data1 : wr_data0;
        oe_d  = last_q ? wr_oe1 : wr_oe0;
        if (!req[last_q] || preempt) begin
          state_d = TURN;
          gnt_d   = '0;
          oe_d    = '0;
          turn_d  = TURN_CNT_W'(TURN_CYC - 1);
        end else if (waiting) begin
          hold_d = sat_inc(hold_q);
        end else begin
          hold_d = '0;
        end
      end
      TURN: begin
        if (turn_q == '0) state_d = IDLE;
        else              turn_d  = turn_q - TURN_CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  for (genvar i = 0; i < W; i++) begin : g_pin
    assign GPIO[i] = oe_q[i] ? out_q[i] : 1'bz;
  end

  gpio_sync #(
    .W           (W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (CLOCK_50),
    .rst_n  (Resetn),
    .pins   (GPIO),
    .synced (rd_data)
  );

`ifdef GPIO_EDGE_DET_EN
  logic [W-1:0] prev_q;

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      prev_q <= '0;
      rise   <= '0;
      fall   <= '0;
    end else begin
      prev_q <= rd_data;
      rise   <= rd_data & ~prev_q;
      fall   <= ~rd_data & prev_q;
    end
  end
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule

// File: tb/tb_gpio_port_arbiter.sv
// Directed and randomized checks of the GPIO header arbiter.
module tb_gpio_port_arbiter;

  localparam int W        = 32;
  localparam int TURN_CYC = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  wire  [W-1:0] gpio;
  logic [1:0]   req;
  logic [1:0]   gnt;
  logic [W-1:0] wr_data0, wr_oe0, wr_data1, wr_oe1;
  logic [W-1:0] rd_data, rise, fall;
  logic         busy;
  logic [W-1:0] ext_drv, ext_oe;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < W; i++) begin : g_ext
    assign gpio[i] = ext_oe[i] ? ext_drv[i] : 1'bz;
  end

  gpio_port_arbiter #(
    .W           (W),
    .TURN_CYC    (TURN_CYC),
    .MAX_HOLD    (8),
    .SYNC_STAGES (2)
  ) dut (
    .CLOCK_50 (clk),
    .Resetn   (rst_n),
    .GPIO     (gpio),
    .req      (req),
    .gnt      (gnt),
    .wr_data0 (wr_data0),
    .wr_oe0   (wr_oe0),
    .wr_data1 (wr_data1),
    .wr_oe1   (wr_oe1),
    .rd_data  (rd_data),
    .busy     (busy),
    .rise     (rise),
    .fall     (fall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 2'b00;
    step();
    step();
    rst_n = 1'b1;
  endtask

  int  gap;
  bit  seen_owner;
  logic [1:0] prev_gnt;

  initial begin
    rst_n    = 1'b0;
    req      = 2'b00;
    wr_data0 = '0; wr_oe0 = '0;
    wr_data1 = '0; wr_oe1 = '0;
    ext_drv  = '0; ext_oe = '0;
    step();
    step();
    chk("rst_gnt",  {30'd0, gnt}, 32'h0);
    chk("rst_oe",   dut.oe_q, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_rd",   rd_data, 32'h0);
    chk("rst_rise", rise, 32'h0);
    chk("rst_fall", fall, 32'h0);
    rst_n = 1'b1;

    // Single requester
    req = 2'b01; wr_oe0 = 32'h0000_00FF; wr_data0 = 32'h0000_00A5;
    step();
    chk("s_gnt",   {30'd0, gnt}, 32'h1);
    chk("s_busy",  {31'd0, busy}, 32'h1);
    chk("s_oe0",   dut.oe_q, 32'h0);
    step();
    chk("s_pins",  {24'd0, gpio[7:0]}, 32'hA5);
    chk("s_oe1",   dut.oe_q, 32'h0000_00FF);
    step();
    chk("s_rd_e",  {24'd0, rd_data[7:0]}, 32'h00);
    step();
    chk("s_rd",    {24'd0, rd_data[7:0]}, 32'hA5);
    req = 2'b00;
    step();
    chk("s_rel_g", {30'd0, gnt}, 32'h0);
    chk("s_rel_o", dut.oe_q, 32'h0);
    chk("s_rel_b", {31'd0, busy}, 32'h1);
    step();
    chk("s_trn_b", {31'd0, busy}, 32'h1);
    step();
    chk("s_idle",  {31'd0, busy}, 32'h0);

    // Contention from a fresh reset: requester 0 first
    do_reset();
    wr_data1 = 32'h1234_5678; wr_oe1 = 32'hFFFF_0000;
    req = 2'b11;
    step();
    chk("c_g0",    {30'd0, gnt}, 32'h1);
    step();
    chk("c_g0b",   {30'd0, gnt}, 32'h1);
    req = 2'b10;
    step();
    chk("c_t1g",   {30'd0, gnt}, 32'h0);
    chk("c_t1o",   dut.oe_q, 32'h0);
    step();
    chk("c_t2g",   {30'd0, gnt}, 32'h0);
    chk("c_t2o",   dut.oe_q, 32'h0);
    chk("c_t2b",   {31'd0, busy}, 32'h1);
    step();
    chk("c_idg",   {30'd0, gnt}, 32'h0);
    chk("c_idb",   {31'd0, busy}, 32'h0);
    step();
    chk("c_g1",    {30'd0, gnt}, 32'h2);
    step();
    chk("c_oe1",   dut.oe_q, 32'hFFFF_0000);
    chk("c_pin1",  {16'd0, gpio[31:16]}, 32'h1234);

    // Preemption with MAX_HOLD = 8
    do_reset();
    req = 2'b01;
    step();
    chk("p_g0",    {30'd0, gnt}, 32'h1);
    req = 2'b11;
    for (int i = 0; i < 7; i++) step();
    chk("p_hold",  {30'd0, gnt}, 32'h1);
    step();
    chk("p_drop",  {30'd0, gnt}, 32'h0);
    chk("p_dropo", dut.oe_q, 32'h0);
    step();
    chk("p_trn",   {31'd0, busy}, 32'h1);
    step();
    chk("p_idle",  {31'd0, busy}, 32'h0);
    step();
    chk("p_g1",    {30'd0, gnt}, 32'h2);
    req = 2'b01;
    step();
    chk("p_rel1",  {30'd0, gnt}, 32'h0);
    step();
    step();
    chk("p_idle2", {30'd0, gnt}, 32'h0);
    step();
    chk("p_reg0",  {30'd0, gnt}, 32'h1);

    // External drive while nothing is granted
    do_reset();
    ext_oe = 32'h0000_FF00; ext_drv = 32'h0000_3C00;
    step();
    chk("e_rd_e",  {24'd0, rd_data[15:8]}, 32'h00);
    step();
    chk("e_rd",    {24'd0, rd_data[15:8]}, 32'h3C);
    step();
`ifdef GPIO_EDGE_DET_EN
    chk("e_rise",  {24'd0, rise[15:8]}, 32'h3C);
    step();
    chk("e_rise0", {24'd0, rise[15:8]}, 32'h00);
`else
    chk("e_rise",  rise, 32'h0);
    step();
    chk("e_fall",  fall, 32'h0);
`endif
    ext_drv = 32'h0000_0000;
    step();
    step();
    chk("e_rd0",   {24'd0, rd_data[15:8]}, 32'h00);
    step();
`ifdef GPIO_EDGE_DET_EN
    chk("e_fallp", {24'd0, fall[15:8]}, 32'h3C);
`else
    chk("e_fallz", fall, 32'h0);
`endif
    ext_oe = '0;

    // Reset while requester 1 drives the whole header
    do_reset();
    wr_data1 = 32'hFFFF_FFFF; wr_oe1 = 32'hFFFF_FFFF;
    req = 2'b10;
    step();
    chk("r_g1",    {30'd0, gnt}, 32'h2);
    step();
    chk("r_pins",  gpio, 32'hFFFF_FFFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_async_o", dut.oe_q, 32'h0);
    chk("r_async_g", {30'd0, gnt}, 32'h0);
    req = 2'b11;
    step();
    rst_n = 1'b1;
    step();
    chk("r_g0",    {30'd0, gnt}, 32'h1);

    // Randomized request toggling
    do_reset();
    gap = 0; seen_owner = 1'b0; prev_gnt = 2'b00;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 7) == 0) req[0] = ~req[0];
      if ($urandom_range(0, 7) == 0) req[1] = ~req[1];
      wr_data0 = $urandom; wr_oe0 = $urandom;
      wr_data1 = $urandom; wr_oe1 = $urandom;
      step();
      chk("x_onehot", {31'd0, $onehot0(gnt)}, 32'h1);
      if (gnt == 2'b00) chk("x_oe_idle", dut.oe_q, 32'h0);
      if (gnt != 2'b00) begin
        if (prev_gnt == 2'b00 && seen_owner)
          chk("x_gap", {31'd0, gap >= TURN_CYC + 1}, 32'h1);
        seen_owner = 1'b1;
        gap = 0;
      end else begin
        gap++;
      end
      prev_gnt = gnt;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
